pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline sequencer for the RISC-V core. It replaces the fixed chain of per-stage instruction registers with a depth-configurable chain that tracks a valid bit per stage. It also implements:
- stall and flush handling;
- load-use hazard detection;
- EX-stage forwarding-select generation.

It sits between instruction memory and the ID/EX/MEM/WB datapath, and drives the PC hold and the ALU operand muxes.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Depth-configurable instruction pipeline sequencer: per-stage valid tracking, stall/flush, load-use
// detection and EX forwarding selects. Define PIPE_HAZARD_FWD_EN to build the forwarding variant.

// Opcode classifier, one instance per stage register.
module phc_decode (
  input  logic [6:0] opcode,
  output logic       wr,
  output logic       ld,
  output logic       use1,
  output logic       use2
);
  always_comb begin
    wr   = 1'b0;
    use1 = 1'b1;
    use2 = 1'b0;
    ld   = (opcode == 7'b0000011);
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111: wr = 1'b1;
      7'b1101111, 7'b0110111, 7'b0010111: begin
        wr   = 1'b1;
        use1 = 1'b0;
      end
      default: ;
    endcase
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: use2 = 1'b1;
      default: ;
    endcase
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = 32,
  parameter int FWD_W      = $clog2(NUM_STAGES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [DATA_W-1:0]                instr_in,
  input  logic                             flush,
  output logic [(NUM_STAGES-1)*DATA_W-1:0] stage_instr,
  output logic [NUM_STAGES-2:0]            stage_valid,
  output logic                             stall_if,
  output logic [FWD_W-1:0]                 fwd_a,
  output logic [FWD_W-1:0]                 fwd_b,
  output logic [4:0]                       wb_rd,
  output logic                             wb_we
);
  localparam int WB = NUM_STAGES - 1;
  localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(32'h0000_0013);

  logic [WB:1][DATA_W-1:0] instr_pipe;
  logic [WB:1]             vld_pipe;
  logic [WB:1]             wr, ld, use1, use2, live_wr, dep;
  logic [WB:1][4:0]        rd, rs1, rs2;

  for (genvar k = 1; k <= WB; k++) begin : g_stage
    assign rd[k]  = instr_pipe[k][11:7];
    assign rs1[k] = instr_pipe[k][19:15];
    assign rs2[k] = instr_pipe[k][24:20];
    phc_decode u_dec (
      .opcode (instr_pipe[k][6:0]),
      .wr     (wr[k]),
      .ld     (ld[k]),
      .use1   (use1[k]),
      .use2   (use2[k])
    );
    // x0 writes and bubbles never produce a dependency
    assign live_wr[k] = vld_pipe[k] & wr[k] & (rd[k] != 5'd0);
    assign dep[k]     = live_wr[k] & vld_pipe[1] &
                        ((use1[1] & (rs1[1] == rd[k])) | (use2[1] & (rs2[1] == rd[k])));
  end

  always_comb begin
    stall_if = 1'b0;
`ifdef PIPE_HAZARD_FWD_EN
    // a load still short of WB cannot be forwarded in time for the consumer's EX
    for (int k = 2; k <= WB - 2; k++)
      if (dep[k] && ld[k]) stall_if = 1'b1;
`else
    for (int k = 2; k <= WB; k++)
      if (dep[k]) stall_if = 1'b1;
`endif
    if (flush) stall_if = 1'b0;
  end

`ifdef PIPE_HAZARD_FWD_EN
  // scan oldest to youngest so the youngest matching writer overrides
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = WB; k >= 3; k--) begin
      if (live_wr[k] && (!ld[k] || k == WB)) begin
        if (vld_pipe[2] && use1[2] && rs1[2] == rd[k]) fwd_a = FWD_W'(k);
        if (vld_pipe[2] && use2[2] && rs2[2] == rd[k]) fwd_b = FWD_W'(k);
      end
    end
  end
`else
  assign fwd_a = '0;
  assign fwd_b = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_pipe <= {WB{BUBBLE}};
      vld_pipe   <= '0;
    end else if (enable) begin
      for (int k = 3; k <= WB; k++) begin
        instr_pipe[k] <= instr_pipe[k-1];
        vld_pipe[k]   <= vld_pipe[k-1];
      end
      if (flush) begin
        instr_pipe[1] <= BUBBLE;
        vld_pipe[1]   <= 1'b0;
        instr_pipe[2] <= BUBBLE;
        vld_pipe[2]   <= 1'b0;
      end else if (stall_if) begin
        instr_pipe[2] <= BUBBLE;
        vld_pipe[2]   <= 1'b0;
      end else begin
        instr_pipe[1] <= instr_in;
        vld_pipe[1]   <= 1'b1;
        instr_pipe[2] <= instr_pipe[1];
        vld_pipe[2]   <= vld_pipe[1];
      end
    end
  end

  assign stage_instr = instr_pipe;
  assign stage_valid = vld_pipe;
  assign wb_rd       = rd[WB];
  assign wb_we       = live_wr[WB];

  // decode fields not consumed at every stage
  logic unused_ok;
  assign unused_ok = ^{instr_pipe, wr, ld, use1, use2, rd, rs1, rs2, dep, live_wr};
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl (NUM_STAGES=5) against a stage-array reference model.
module tb_pipe_hazard_ctrl;
  localparam int NS = 5;
  localparam int DW = 32;
  localparam int FW = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b1, flush = 1'b0;
  logic [DW-1:0] instr_in = '0;
  logic [(NS-1)*DW-1:0] stage_instr;
  logic [NS-2:0] stage_valid;
  logic stall_if, wb_we;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [4:0] wb_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mi [1:4];
  bit          mv [1:4];

  pipe_hazard_ctrl #(.NUM_STAGES(NS), .DATA_W(DW), .FWD_W(FW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .instr_in(instr_in), .flush(flush),
    .stage_instr(stage_instr), .stage_valid(stage_valid), .stall_if(stall_if),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_rd(wb_rd), .wb_we(wb_we)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_wr(logic [31:0] i);
    case (i[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic bit m_use1(logic [31:0] i);
    return !(i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction
  function automatic bit m_use2(logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit m_reads(logic [31:0] i, logic [4:0] r);
    return (m_use1(i) && i[19:15] == r) || (m_use2(i) && i[24:20] == r);
  endfunction
  function automatic bit m_writer(int k);
    return mv[k] && m_wr(mi[k]) && mi[k][11:7] != 5'd0;
  endfunction

  function automatic bit m_stall(logic fl);
    int hi = FWD ? NS - 3 : NS - 1;
    if (fl || !mv[1]) return 1'b0;
    for (int k = 2; k <= hi; k++)
      if (m_writer(k) && m_reads(mi[1], mi[k][11:7]) && (!FWD || mi[k][6:0] == 7'b0000011))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_fwd(bit second);
    logic [4:0] src;
    bit used;
    if (!FWD || !mv[2]) return 3'd0;
    used = second ? m_use2(mi[2]) : m_use1(mi[2]);
    src  = second ? mi[2][24:20] : mi[2][19:15];
    if (!used) return 3'd0;
    for (int k = 3; k <= NS - 1; k++)
      if (m_writer(k) && mi[k][11:7] == src && (mi[k][6:0] != 7'b0000011 || k == NS - 1))
        return 3'(k);
    return 3'd0;
  endfunction

  task automatic model_step();
    logic [31:0] ni [1:4];
    bit nv [1:4];
    bit st;
    if (rst) begin
      for (int k = 1; k <= 4; k++) begin ni[k] = NOP; nv[k] = 1'b0; end
    end else if (!enable) begin
      for (int k = 1; k <= 4; k++) begin ni[k] = mi[k]; nv[k] = mv[k]; end
    end else begin
      st = m_stall(flush);
      ni[4] = mi[3]; nv[4] = mv[3];
      ni[3] = mi[2]; nv[3] = mv[2];
      if (flush) begin
        ni[1] = NOP; nv[1] = 1'b0; ni[2] = NOP; nv[2] = 1'b0;
      end else if (st) begin
        ni[1] = mi[1]; nv[1] = mv[1]; ni[2] = NOP; nv[2] = 1'b0;
      end else begin
        ni[1] = instr_in; nv[1] = 1'b1; ni[2] = mi[1]; nv[2] = mv[1];
      end
    end
    for (int k = 1; k <= 4; k++) begin mi[k] = ni[k]; mv[k] = nv[k]; end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; flush = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111,
                            7'b0110111, 7'b0010111, 7'b0100011, 7'b1100011};
    logic [31:0] r = $urandom;
    return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:12],
            5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; instr_in = 32'h002081B3;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (stage_instr !== {4{NOP}}) begin errors++; $display("FAIL reset_instr got %h exp %h", stage_instr, {4{NOP}}); end
    checks++; if (stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b exp 0000", stage_valid); end
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb got we=%b rd=%0d exp 0/0", wb_we, wb_rd); end
    checks++; if (stall_if !== 1'b0 || fwd_a !== 3'd0 || fwd_b !== 3'd0) begin errors++; $display("FAIL reset_hazard got stall=%b fa=%0d fb=%0d exp 0", stall_if, fwd_a, fwd_b); end
  endtask

  task automatic test_alu_raw();
    int stalls = 0;
    bit seen = 1'b0;
    do_reset();
    instr_in = 32'h002081B3; tick();
    instr_in = 32'h40118233; tick();
    instr_in = NOP;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (stall_if === 1'b1) stalls++;
      if (mv[2] && mi[2] == 32'h40118233 && !seen) begin
        seen = 1'b1;
        checks++; if (fwd_a !== (FWD ? 3'd3 : 3'd0)) begin errors++; $display("FAIL raw_fwd_a got %0d exp %0d", fwd_a, FWD ? 3 : 0); end
        checks++; if (fwd_b !== 3'd0) begin errors++; $display("FAIL raw_fwd_b got %0d exp 0", fwd_b); end
      end
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL raw_reach_ex got 0 exp 1"); end
    checks++; if (stalls != (FWD ? 0 : 3)) begin errors++; $display("FAIL raw_stalls got %0d exp %0d", stalls, FWD ? 0 : 3); end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    bit seen = 1'b0;
    bit st;
    do_reset();
    instr_in = 32'h0000B283; tick();
    instr_in = 32'h00528333; tick();
    instr_in = NOP;
    for (int c = 0; c < 10; c++) begin
      #1;
      st = stall_if;
      if (st === 1'b1) stalls++;
      if (mv[2] && mi[2] == 32'h00528333 && !seen) begin
        seen = 1'b1;
        checks++; if (fwd_a !== (FWD ? 3'd4 : 3'd0) || fwd_b !== (FWD ? 3'd4 : 3'd0)) begin
          errors++; $display("FAIL ldu_fwd got a=%0d b=%0d exp %0d", fwd_a, fwd_b, FWD ? 4 : 0); end
      end
      tick();
      if (st === 1'b1) begin
        checks++; if (stage_valid[1] !== 1'b0 || stage_instr[2*DW-1 -: DW] !== NOP) begin
          errors++; $display("FAIL ldu_bubble got v=%b i=%h exp 0/%h", stage_valid[1], stage_instr[2*DW-1 -: DW], NOP); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL ldu_reach_ex got 0 exp 1"); end
    checks++; if (stalls != (FWD ? 1 : 3)) begin errors++; $display("FAIL ldu_stalls got %0d exp %0d", stalls, FWD ? 1 : 3); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 4; i++) begin instr_in = 32'(i << 20) | NOP; tick(); end
    instr_in = 32'h0050_0013; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (stage_valid !== 4'b1100) begin errors++; $display("FAIL flush_valid got %b exp 1100", stage_valid); end
    checks++; if (stage_instr !== {32'h0020_0013, 32'h0030_0013, NOP, NOP}) begin
      errors++; $display("FAIL flush_instr got %h exp %h", stage_instr, {32'h0020_0013, 32'h0030_0013, NOP, NOP}); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    instr_in = 32'h0000B283; tick();
    instr_in = 32'h00528333; tick();
    instr_in = NOP;
    #1;
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fs_pre_stall got %b exp 1", stall_if); end
    flush = 1'b1;
    #1;
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fs_override got %b exp 0", stall_if); end
    tick();
    flush = 1'b0;
    checks++; if (stage_valid !== 4'b0100 || stage_instr[DW-1:0] !== NOP || stage_instr[3*DW-1 -: DW] !== 32'h0000B283) begin
      errors++; $display("FAIL fs_result got v=%b s1=%h s3=%h exp 0100/%h/0000b283", stage_valid, stage_instr[DW-1:0], stage_instr[3*DW-1 -: DW], NOP); end
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 1; i <= 3; i++) begin instr_in = 32'(i << 20) | NOP; tick(); end
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      instr_in = rand_instr();
      flush = (c == 1);
      tick();
      checks++; if (stage_instr !== {NOP, 32'h0010_0013, 32'h0020_0013, 32'h0030_0013} || stage_valid !== 4'b0111) begin
        errors++; $display("FAIL enable_hold c=%0d got %h/%b exp held", c, stage_instr, stage_valid); end
    end
    flush = 1'b0; enable = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      enable   = ($urandom_range(0, 99) < 85);
      flush    = ($urandom_range(0, 99) < 10);
      instr_in = rand_instr();
      #1;
      checks++; if (stage_instr !== {mi[4], mi[3], mi[2], mi[1]}) begin errors++; $display("FAIL rnd_instr c=%0d got %h exp %h", c, stage_instr, {mi[4], mi[3], mi[2], mi[1]}); end
      checks++; if (stage_valid !== {mv[4], mv[3], mv[2], mv[1]}) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, stage_valid, {mv[4], mv[3], mv[2], mv[1]}); end
      checks++; if (stall_if !== m_stall(flush)) begin errors++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, stall_if, m_stall(flush)); end
      checks++; if (fwd_a !== m_fwd(1'b0)) begin errors++; $display("FAIL rnd_fwd_a c=%0d got %0d exp %0d", c, fwd_a, m_fwd(1'b0)); end
      checks++; if (fwd_b !== m_fwd(1'b1)) begin errors++; $display("FAIL rnd_fwd_b c=%0d got %0d exp %0d", c, fwd_b, m_fwd(1'b1)); end
      checks++; if (wb_rd !== mi[4][11:7] || wb_we !== m_writer(4)) begin
        errors++; $display("FAIL rnd_wb c=%0d got rd=%0d we=%b exp rd=%0d we=%b", c, wb_rd, wb_we, mi[4][11:7], m_writer(4)); end
      tick();
    end
    rst = 1'b0; enable = 1'b1; flush = 1'b0;
  endtask

  initial begin
    for (int k = 1; k <= 4; k++) begin mi[k] = NOP; mv[k] = 1'b0; end
    test_reset();
    test_alu_raw();
    test_load_use();
    test_flush();
    test_flush_stall();
    test_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
